// File: rtl/writeback_stage_pkg.sv
// Shared types and encodings for the writeback stage.
// Holds the write-data select codes, load funct3 values and the WB entry.
package writeback_stage_pkg;

  localparam int XLEN_C = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic              valid;
    logic              regWrite;
    logic [4:0]        rd;
    wb_sel_e           wbSel;
    logic [XLEN_C-1:0] aluResult;
    logic [XLEN_C-1:0] memData;
    logic [2:0]        funct3;
    logic [XLEN_C-1:0] pcPlus4;
    logic [XLEN_C-1:0] imm;
  } mem_wb_t;

  function automatic logic [XLEN_C-1:0] ext8(
    input logic [7:0] b,
    input logic       sgn
  );
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [XLEN_C-1:0] ext16(
    input logic [15:0] h,
    input logic        sgn
  );
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Load data extraction and alignment check.
// Purely combinational; reserved funct3 yields zero data.
module load_extend
  import writeback_stage_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  input  logic [XLEN_C-1:0] word,
  output logic [XLEN_C-1:0] data,
  output logic              misaligned
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  always_comb begin
    bsel = word[7:0];
    unique case (offset)
      2'd0: bsel = word[7:0];
      2'd1: bsel = word[15:8];
      2'd2: bsel = word[23:16];
      2'd3: bsel = word[31:24];
      default: bsel = word[7:0];
    endcase
  end

  assign hsel = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    unique case (1'b1)
      (funct3 == F3_LB): begin
        data = ext8(bsel, 1'b1);
      end
      (funct3 == F3_LBU): begin
        data = ext8(bsel, 1'b0);
      end
      (funct3 == F3_LH): begin
        data       = ext16(hsel, 1'b1);
        misaligned = offset[0];
      end
      (funct3 == F3_LHU): begin
        data       = ext16(hsel, 1'b0);
        misaligned = offset[0];
      end
      (funct3 == F3_LW): begin
        data       = word;
        misaligned = (offset != 2'd0);
      end
      default: begin
        data       = '0;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: one entry register, write-data mux, retire counter.
// Each valid entry acts exactly once, however long it is stalled.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_regWrite,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_wbSel,
  input  logic [XLEN-1:0]  in_aluResult,
  input  logic [XLEN-1:0]  in_memData,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_pcPlus4,
  input  logic [XLEN-1:0]  in_imm,
  output logic             writeEnable,
  output logic [4:0]       writeReg,
  output logic [XLEN-1:0]  writeData,
  output logic             load_misaligned,
  output logic [CNT_W-1:0] retired
);

  mem_wb_t d;
  mem_wb_t q;
  logic    done_q;
  logic    first;
  logic    is_load;
  logic    mis;
  logic    ld_mis;
  logic [XLEN_C-1:0] ld_data;

  always_comb begin
    d           = '0;
    d.valid     = in_valid & ~flush;
    d.regWrite  = in_regWrite;
    d.rd        = in_rd;
    d.wbSel     = wb_sel_e'(in_wbSel);
    d.aluResult = in_aluResult;
    d.memData   = in_memData;
    d.funct3    = in_funct3;
    d.pcPlus4   = in_pcPlus4;
    d.imm       = in_imm;
  end

  // done marks an entry that has already been presented once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q       <= '0;
      done_q  <= 1'b0;
      retired <= '0;
    end else begin
      if (!stall) begin
        q      <= d;
        done_q <= 1'b0;
      end else begin
        done_q <= done_q | q.valid;
      end
      retired <= retired + CNT_W'(first);
    end
  end

  assign first = q.valid & ~done_q;

  load_extend u_load_extend (
    .funct3     (q.funct3),
    .offset     (q.aluResult[1:0]),
    .word       (q.memData),
    .data       (ld_data),
    .misaligned (ld_mis)
  );

  assign is_load = (q.wbSel == WB_MEM);
  assign mis     = is_load & ld_mis;

  always_comb begin
    writeData = q.aluResult;
    unique case (1'b1)
      (q.wbSel == WB_ALU): writeData = q.aluResult;
      (q.wbSel == WB_MEM): writeData = ld_data;
      (q.wbSel == WB_PC4): writeData = q.pcPlus4;
      (q.wbSel == WB_IMM): writeData = q.imm;
      default:             writeData = q.aluResult;
    endcase
  end

  assign writeReg        = q.rd;
  assign writeEnable     = first & q.regWrite
                         & (q.rd != 5'd0) & ~mis;
  assign load_misaligned = first & mis;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized bench for writeback_stage against a behavioural model.
// Uses a narrow retire counter so wraparound is exercised.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic          flush;
  logic          in_valid;
  logic          in_regWrite;
  logic [4:0]    in_rd;
  logic [1:0]    in_wbSel;
  logic [31:0]   in_aluResult;
  logic [31:0]   in_memData;
  logic [2:0]    in_funct3;
  logic [31:0]   in_pcPlus4;
  logic [31:0]   in_imm;
  logic          writeEnable;
  logic [4:0]    writeReg;
  logic [31:0]   writeData;
  logic          load_misaligned;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  writeback_stage #(.XLEN(32), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_regWrite     (in_regWrite),
    .in_rd           (in_rd),
    .in_wbSel        (in_wbSel),
    .in_aluResult    (in_aluResult),
    .in_memData      (in_memData),
    .in_funct3       (in_funct3),
    .in_pcPlus4      (in_pcPlus4),
    .in_imm          (in_imm),
    .writeEnable     (writeEnable),
    .writeReg        (writeReg),
    .writeData       (writeData),
    .load_misaligned (load_misaligned),
    .retired         (retired)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // model: the entry sitting in WB and whether it is on its first cycle
  bit          m_fresh = 0;
  bit          m_rw    = 0;
  logic [4:0]  m_rd    = '0;
  logic [1:0]  m_sel   = '0;
  logic [31:0] m_alu   = '0;
  logic [31:0] m_mem   = '0;
  logic [2:0]  m_f3    = '0;
  logic [31:0] m_pc4   = '0;
  logic [31:0] m_imm   = '0;
  logic [31:0] m_ret   = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
      input int off, input logic [31:0] mem);
    logic [31:0] v;
    v = 0;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (mem >> (8 * off)) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (mem >> (16 * (off / 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else if (f3 == 3'd2) begin
      v = mem;
    end
    return v;
  endfunction

  function automatic bit ref_mis(input logic [1:0] sel,
      input logic [2:0] f3, input int off);
    if (sel != 2'd1) return 0;
    if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) == 1;
    if (f3 == 3'd2) return off != 0;
    return 0;
  endfunction

  function automatic logic [31:0] ref_data();
    case (m_sel)
      2'd0:    return m_alu;
      2'd1:    return ref_load(m_f3, int'(m_alu % 4), m_mem);
      2'd2:    return m_pc4;
      default: return m_imm;
    endcase
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_fresh = 0; m_rw = 0; m_rd = 0; m_sel = 0; m_alu = 0;
      m_mem = 0; m_f3 = 0; m_pc4 = 0; m_imm = 0; m_ret = 0;
    end else begin
      m_ret = (m_ret + 32'(m_fresh)) % (1 << CW);
      if (!stall) begin
        m_fresh = in_valid && !flush;
        m_rw = in_regWrite; m_rd = in_rd; m_sel = in_wbSel;
        m_alu = in_aluResult; m_mem = in_memData;
        m_f3 = in_funct3; m_pc4 = in_pcPlus4; m_imm = in_imm;
      end else begin
        m_fresh = 0;
      end
    end
  endtask

  task automatic check_all();
    bit mis;
    bit we;
    mis = m_fresh && ref_mis(m_sel, m_f3, int'(m_alu % 4));
    we  = m_fresh && m_rw && m_rd != 0 && !mis;
    chk("we",      32'(writeEnable),     32'(we));
    chk("wreg",    32'(writeReg),        32'(m_rd));
    chk("wdata",   writeData,            ref_data());
    chk("lmis",    32'(load_misaligned), 32'(mis));
    chk("retired", 32'(retired),         m_ret);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_in(input bit v, input bit rw, input logic [4:0] rd,
      input logic [1:0] sel, input logic [31:0] alu,
      input logic [31:0] mem, input logic [2:0] f3,
      input logic [31:0] pc4, input logic [31:0] imm);
    in_valid = v; in_regWrite = rw; in_rd = rd; in_wbSel = sel;
    in_aluResult = alu; in_memData = mem; in_funct3 = f3;
    in_pcPlus4 = pc4; in_imm = imm;
  endtask

  task automatic rand_in();
    rst_n = ($urandom_range(0, 49) != 0);
    stall = ($urandom_range(0, 3) == 0);
    flush = ($urandom_range(0, 7) == 0);
    set_in(($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
           2'($urandom), $urandom, $urandom, 3'($urandom),
           $urandom, $urandom);
  endtask

  int pulses;
  logic [31:0] r0;

  initial begin
    rst_n = 0; stall = 0; flush = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_wd", writeData, 32'h0);
    chk("rst_ret", 32'(retired), 32'h0);
    rst_n = 1;

    set_in(1, 1, 5'd5, 2'd1, 32'h2, 32'h80FF7F01, F3_LB, 0, 0);
    step();
    chk("lb_data", writeData, 32'hFFFFFFFF);
    chk("lb_we", 32'(writeEnable), 32'd1);
    stall = 1;
    step();
    chk("lb_we_once", 32'(writeEnable), 32'd0);
    stall = 0;
    set_in(1, 1, 5'd5, 2'd1, 32'h2, 32'h80FF7F01, F3_LBU, 0, 0);
    step();
    chk("lbu_data", writeData, 32'h000000FF);

    set_in(1, 1, 5'd7, 2'd1, 32'h1, 32'h12345678, F3_LH, 0, 0);
    step();
    r0 = 32'(retired);
    chk("lh_lmis", 32'(load_misaligned), 32'd1);
    chk("lh_we", 32'(writeEnable), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("lh_lmis_once", 32'(load_misaligned), 32'd0);
    chk("lh_ret", 32'(retired), (r0 + 1) % (1 << CW));

    set_in(1, 1, 5'd0, 2'd0, 32'h1234, 0, 0, 0, 0);
    step();
    chk("x0_we", 32'(writeEnable), 32'd0);

    set_in(1, 1, 5'd1, 2'd2, 0, 0, 0, 32'h104, 0);
    step();
    pulses = int'(writeEnable);
    chk("jal_data", writeData, 32'h104);
    stall = 1; flush = 1;
    repeat (3) begin
      step();
      pulses += int'(writeEnable);
    end
    chk("jal_pulses", 32'(pulses), 32'd1);
    stall = 0;
    step();
    chk("flush_we", 32'(writeEnable), 32'd0);
    flush = 0;

    set_in(1, 1, 5'd9, 2'd3, 0, 0, 0, 0, 32'hABCD0000);
    step();
    stall = 1; rst_n = 0;
    step();
    chk("rst_mid_we", 32'(writeEnable), 32'd0);
    chk("rst_mid_wd", writeData, 32'h0);
    chk("rst_mid_ret", 32'(retired), 32'h0);
    rst_n = 1; stall = 0;

    repeat (800) begin
      rand_in();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width; only 32 is supported.
REQ-002 Parameter CNT_W, default 32: width of the retire counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous and active-low, sampled on posedge clk.
REQ-005 stall  input  1  hold the WB entry this cycle.
REQ-006 flush  input  1  replace the incoming entry with a bubble.
REQ-007 in_valid  input  1  the MEM-stage entry is valid.
REQ-008 in_regWrite  input  1  the instruction writes rd.
REQ-009 in_rd  input  5  destination register index.
REQ-010 in_wbSel  input  2  write-data source: 00 ALU, 01 load, 10 PC+4, 11 immediate.
REQ-011 in_aluResult  input  32  ALU result; bits [1:0] are the load byte offset.
REQ-012 in_memData  input  32  raw aligned memory word.
REQ-013 in_funct3  input  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
REQ-014 in_pcPlus4  input  32  link value.
REQ-015 in_imm  input  32  U-type immediate.
REQ-016 writeEnable  output  1  write strobe to the register file write port.
REQ-017 writeReg  output  5  register file write index.
REQ-018 writeData  output  32  register file write data.
REQ-019 load_misaligned  output  1  one-cycle pulse for a retired misaligned load.
REQ-020 retired  output  CNT_W  count of retired valid entries.

Function
REQ-021 The block SHALL hold one WB entry register that captures all in_* fields on posedge clk when stall=0.
REQ-022 When flush=1 and stall=0, the block SHALL capture valid=0; flush SHALL take priority over the capture of in_valid.
REQ-023 When stall=1, the block SHALL hold the entry unchanged regardless of flush.
REQ-024 A "done" flag SHALL set in the first cycle a valid entry is presented, clear on every new capture, and make writeEnable, load_misaligned and retired act exactly once per entry.
REQ-025 writeEnable SHALL equal valid_q & regWrite_q & (rd_q != 0) & ~done & ~misaligned; x0 SHALL never be written.
REQ-026 writeReg SHALL equal rd_q, and writeData SHALL be the combinational mux of the registered fields; latency SHALL be one cycle from the MEM-stage inputs to the write strobe, with the register file committing on the following edge.
REQ-027 Load extraction SHALL use offset = aluResult_q[1:0]:
- lb/lbu select byte [8*offset+7 : 8*offset], with sign extension for lb and zero extension for lbu.
- lh/lhu select halfword [16*offset[1]+15 : 16*offset[1]], with sign or zero extension.
- lw passes the word.
- Reserved funct3 values SHALL produce 0.
REQ-028 A load is misaligned when it is lh/lhu with offset[0]=1, or lw with offset!=0. A misaligned load SHALL suppress writeEnable and pulse load_misaligned for one cycle.
REQ-029 retired SHALL increment by 1 for each valid entry on its first cycle, including misaligned loads and rd=0, and SHALL wrap modulo 2^CNT_W.
REQ-030 in_wbSel=11 SHALL select in_imm; when wbSel is not 01, funct3 SHALL be ignored.

Reset
REQ-031 With rst_n=0 at posedge clk, the block SHALL set valid_q=0, done=0, retired=0 and all entry fields to 0.
REQ-032 Because of REQ-031, writeEnable=0, writeReg=0, writeData=0 and load_misaligned=0 during reset and in the first cycle after it.
REQ-033 Reset SHALL override stall and flush, and an entry present mid-stall SHALL be discarded without a write.

Structure
REQ-034 A shared package SHALL hold the wbSel encodings (WB_ALU, WB_MEM, WB_PC4, WB_IMM) and the load funct3 constants.
REQ-035 Load extraction and the misalignment check SHALL be one combinational sub-module, load_extend, instantiated once.

Verification
REQ-036 Scenario: lb, memData=0x80FF7F01, aluResult=...02 -> writeData=0xFFFFFFFF? No: byte2=0xFF, so writeData=0xFFFFFFFF; with lbu -> 0x000000FF; writeEnable=1 for exactly one cycle.
REQ-037 Scenario: lh with offset=1 -> writeEnable=0, load_misaligned=1 for one cycle, retired +1.
REQ-038 Scenario: ALU write with rd=0, aluResult=0x1234 -> writeEnable=0, retired +1.
REQ-039 Scenario: jal, rd=1, pcPlus4=0x104, stall held 3 cycles -> a single writeEnable pulse with writeReg=1, writeData=0x104, retired +1.
REQ-040 Scenario: flush=1 and stall=0 with in_valid=1 -> no write; flush=1 with stall=1 -> the held entry writes once.
REQ-041 Scenario: rst_n=0 while a valid entry is stalled -> no write, retired=0 and all outputs 0 on the next cycle.
